uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, the counterpart to the existing uart_tx in the MMIO UART peripheral.
- Format is 8N1, LSB first, idle high, with the same CLKS_PER_BIT timing parameter as uart_tx.
- Synchronises the asynchronous rx line, samples each bit at mid-bit and presents a received byte with a one-cycle valid strobe.
- Flags frames whose stop bit is bad.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Must be >= 4; benches use 4.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- rx  input  1  serial input; asynchronous, idle high
- rx_data  output  8  last correctly received byte; held until the next good frame
- rx_valid  output  1  one-cycle pulse; rx_data is new this cycle
- rx_busy  output  1  high whenever state != IDLE
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset: when rst_n is low at a posedge, the block enters IDLE, clears all counters and the shift register, sets rx_data=0, drives rx_valid/frame_err/rx_busy low, and sets both sync flops to 1. Reset mid-frame aborts the frame with no pulse.
- Synchroniser: 2-flop synchroniser on rx produces rx_s. All decisions use rx_s only, which lags rx by 2 cycles.
- Counters: clk_cnt, wide enough for CLKS_PER_BIT-1; bit_idx, 3 bits.
- IDLE:
  - rx_s==0 -> START, clk_cnt=0.
  - Otherwise stay.
- START:
  - Increment clk_cnt until clk_cnt==(CLKS_PER_BIT-1)/2 (mid start bit).
  - At that point, if rx_s==0 -> DATA with clk_cnt=0, bit_idx=0.
  - If rx_s==1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - Increment clk_cnt. When clk_cnt==CLKS_PER_BIT-1: sample rx_s into the shift register (shift right, new bit into bit 7), set clk_cnt=0, increment bit_idx.
  - The sample taken with bit_idx==7 -> STOP.
- STOP:
  - Count CLKS_PER_BIT-1 the same way, then sample rx_s.
  - Sample 1: load rx_data from the shift register, pulse rx_valid for exactly one cycle (the cycle after the sample edge), go to IDLE.
  - Sample 0: leave rx_data unchanged, pulse frame_err for one cycle, go to WAIT_IDLE.
- WAIT_IDLE (break/garbage recovery): stay while rx_s==0; go to IDLE on rx_s==1. A continuous break yields exactly one frame_err.
- rx_valid and frame_err are never high in the same cycle, and never high for two consecutive cycles.
- Back-to-back frames: the block returns to IDLE half a bit before the end of the stop bit, so it must catch a start bit that immediately follows a stop bit with no extra idle.
- Latency: from the rx start-bit falling edge to rx_valid, 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles ±1. Benches check with a ±1-cycle window, not an exact cycle.
- No overrun detection. Consumers must take rx_data within one frame time.
- No parity; data is 8 bits only.

Test Plan:
- Loopback: uart_tx.tx -> uart_rx.rx, CLKS_PER_BIT=4, send 0x41 -> one rx_valid pulse, rx_data==0x41, frame_err never high, rx_busy low after the frame.
- Pattern sweep via loopback: 0x00, 0xFF, 0x55, 0xAA, 0x80, 0x01 sent back-to-back with tx_start reasserted on tx_done -> six rx_valid pulses with matching bytes in order, no frame_err.
- Framing error: bench drives start bit, data 0x3C, stop bit held 0 for 3 bit periods, then 1 -> exactly one frame_err pulse, no rx_valid, rx_data keeps its previous value, rx_busy stays high until rx returns high, after which the next good frame 0x7E is received correctly.
- Glitch rejection: rx low for 1 clk cycle, then high -> enter START, return to IDLE; no rx_valid, no frame_err; rx_busy low within CLKS_PER_BIT cycles.
- Reset mid-frame: start sending 0xC3, assert rst_n low for 2 cycles during data bit 4 -> rx_busy=0, rx_data=0, no pulses. Then release reset with rx idle high, send 0x5A -> rx_valid with 0x5A.
- Sync/idle robustness: hold rx high for 50 cycles after reset -> rx_busy, rx_valid and frame_err remain 0 throughout.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle high.
// Samples each bit at mid-bit from a 2-flop synchronised copy of rx.
// A good frame updates rx_data and pulses rx_valid for one cycle.
// A low stop bit pulses frame_err and waits for the line to return high.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_BIT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] clk_cnt, clk_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    data_next;
  logic          valid_next, err_next;

  // Two-flop synchroniser; both stages reset to the idle (high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      clk_cnt   <= clk_cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      rx_data   <= data_next;
      rx_valid  <= valid_next;
      frame_err <= err_next;
    end
  end

  // Next-state and datapath decode; START counts to mid start bit so every
  // later full-bit count lands in the middle of a data or stop bit.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    data_next    = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next   = START;
          clk_cnt_next = '0;
        end
      end

      START: begin
        if (clk_cnt == HALF_BIT) begin
          clk_cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt == LAST_CLK) begin
          shift_next   = {rx_s, shift[7:1]};
          clk_cnt_next = '0;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and compares the received
// bytes, pulses and timing against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int EXP_LAT = 2 + (CPB - 1) / 2 + 9 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_cnt = 0;
  int overlap_cnt = 0;
  int last_valid_cyc = 0;
  logic prev_pulse = 1'b0;
  logic [7:0] got_q[$];

  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int start_cyc = 0;
  int cmp_idx = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc++;

  // Output monitor, sampling 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      got_q.push_back(rx_data);
      last_valid_cyc = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
    if (rx_busy === 1'b1) busy_cnt++;
    if ((rx_valid === 1'b1 && frame_err === 1'b1) ||
        ((rx_valid === 1'b1 || frame_err === 1'b1) && prev_pulse))
      overlap_cnt++;
    prev_pulse = (rx_valid === 1'b1) || (frame_err === 1'b1);
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitBits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame; stop_low > 0 holds the stop bit low for that many bit
  // periods before releasing the line. The model records only good frames.
  task automatic applyStimulus(input logic [7:0] b, input int stop_low);
    rx = 1'b0;
    start_cyc = cyc;
    waitBits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitBits(1);
    end
    if (stop_low > 0) begin
      rx = 1'b0;
      waitBits(stop_low);
    end
    rx = 1'b1;
    waitBits(1);
    if (stop_low == 0) begin
      exp_q.push_back(b);
      exp_data = b;
    end
  endtask

  task automatic checkQueue(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    while (cmp_idx < exp_q.size() && cmp_idx < got_q.size()) begin
      checkOutput({tag, "_byte"}, got_q[cmp_idx], exp_q[cmp_idx]);
      cmp_idx++;
    end
    cmp_idx = exp_q.size();
  endtask

  initial begin
    int v0, e0, b0, lat;
    logic [7:0] patterns[6];
    logic [7:0] c3;

    patterns = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80, 8'h01};
    c3 = 8'hC3;

    // Reset state.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_busy", rx_busy, 1'b0);
    checkOutput("reset_valid", rx_valid, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;

    // Idle robustness: 50 cycles of high line.
    b0 = busy_cnt; v0 = valid_cnt; e0 = err_cnt;
    idle(50);
    checkOutput("idle_busy_cycles", busy_cnt - b0, 0);
    checkOutput("idle_valid_pulses", valid_cnt - v0, 0);
    checkOutput("idle_err_pulses", err_cnt - e0, 0);

    // Single frame 0x41 with latency check.
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(8'h41, 0);
    idle(2 * CPB);
    lat = last_valid_cyc - start_cyc;
    checkOutput("single_valid_pulses", valid_cnt - v0, 1);
    checkOutput("single_err_pulses", err_cnt - e0, 0);
    checkOutput("single_rx_data", rx_data, exp_data);
    checkOutput("single_busy_after", rx_busy, 1'b0);
    checkOutput("single_latency_window", (lat >= EXP_LAT - 1 && lat <= EXP_LAT + 1), 1'b1);
    checkQueue("single");

    // Pattern sweep, back-to-back frames with no extra idle.
    e0 = err_cnt;
    foreach (patterns[i]) applyStimulus(patterns[i], 0);
    idle(2 * CPB);
    checkOutput("sweep_err_pulses", err_cnt - e0, 0);
    checkOutput("sweep_rx_data", rx_data, exp_data);
    checkQueue("sweep");

    // Random bytes with random gaps of zero to two bit periods.
    e0 = err_cnt;
    for (int n = 0; n < 12; n++) begin
      applyStimulus(8'($urandom), 0);
      waitBits(int'($urandom_range(0, 2)));
    end
    idle(2 * CPB);
    checkOutput("random_err_pulses", err_cnt - e0, 0);
    checkOutput("random_rx_data", rx_data, exp_data);
    checkQueue("random");

    // Framing error: stop bit low for three bit periods.
    v0 = valid_cnt; e0 = err_cnt;
    applyStimulus(8'h3C, 3);
    checkOutput("ferr_pulses", err_cnt - e0, 1);
    checkOutput("ferr_valid_pulses", valid_cnt - v0, 0);
    checkOutput("ferr_rx_data_kept", rx_data, exp_data);
    idle(2 * CPB);
    checkOutput("ferr_busy_after_high", rx_busy, 1'b0);
    v0 = valid_cnt;
    applyStimulus(8'h7E, 0);
    idle(2 * CPB);
    checkOutput("ferr_recover_valid", valid_cnt - v0, 1);
    checkOutput("ferr_recover_data", rx_data, 8'h7E);
    checkQueue("ferr");

    // Busy must stay high while the line is held low after a bad stop bit.
    rx = 1'b0;
    waitBits(1);
    for (int i = 0; i < 8; i++) begin
      rx = 1'b0;
      waitBits(1);
    end
    e0 = err_cnt;
    waitBits(3);
    checkOutput("break_busy_held", rx_busy, 1'b1);
    checkOutput("break_single_err", err_cnt - e0, 1);
    idle(2 * CPB);
    checkOutput("break_busy_released", rx_busy, 1'b0);

    // Glitch: one cycle low, then high.
    b0 = busy_cnt; v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 3) @(negedge clk);
    checkOutput("glitch_entered_start", (busy_cnt > b0), 1'b1);
    checkOutput("glitch_busy_low", rx_busy, 1'b0);
    checkOutput("glitch_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);

    // Reset in the middle of data bit 4 of 0xC3.
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    waitBits(1);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      waitBits(1);
    end
    rx = c3[4];
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", rx_busy, 1'b0);
    checkOutput("rst_mid_rx_data", rx_data, 8'h00);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_data = 8'h00;
    idle(3 * CPB);
    checkOutput("rst_mid_no_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    checkOutput("rst_mid_data_after", rx_data, exp_data);
    v0 = valid_cnt;
    applyStimulus(8'h5A, 0);
    idle(2 * CPB);
    checkOutput("rst_recover_valid", valid_cnt - v0, 1);
    checkOutput("rst_recover_data", rx_data, 8'h5A);
    checkQueue("rst");

    // Pulse hygiene across the whole run.
    checkOutput("pulse_overlap_or_repeat", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
